// File: rtl/jtag_master.sv
// JTAG initiator: runs a TAP reset/idle sequence after reset, then performs one
// complete IR or DR scan per accepted command, Run-Test/Idle to Run-Test/Idle.
module jtag_master #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic               CLK,
  input  logic               TRST_N,
  input  logic               Start,
  input  logic               IsIR,
  input  logic [LEN_W-1:0]   Len,
  input  logic [MAX_LEN-1:0] DataIn,
  input  logic               TDO,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [MAX_LEN-1:0] DataOut
);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {INIT, IDLE, HEAD, SHIFT, TAIL, FIN} state_t;

  state_t             state, state_n;
  logic [LEN_W-1:0]   cnt, cnt_n, len_q;
  logic [HW-1:0]      half;
  logic               ir_q;
  logic [MAX_LEN-1:0] din_q;
  logic               running, half_end, rise, fall, len_ok, accept, reject;
  logic [1:0]         pins_n;

  assign running  = state inside {INIT, HEAD, SHIFT, TAIL};
  assign half_end = running && (half == HW'(CLK_DIV - 1));
  assign rise     = half_end && !TCK;
  assign fall     = half_end && TCK;
  assign len_ok   = (Len != '0) && (Len <= LEN_W'(MAX_LEN));

  // {TMS, TDI} for slot c of state st; loaded at the slot's start
  function automatic logic [1:0] slot_pins(input state_t st, input logic [LEN_W-1:0] c);
    case (st)
      INIT:    return {c < LEN_W'(5), 1'b0};
      HEAD:    return {ir_q ? (c < LEN_W'(2)) : (c == '0), 1'b0};
      SHIFT:   return {c == len_q - LEN_W'(1), din_q[c[IW-1:0]]};
      TAIL:    return {c == '0, 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  assign pins_n = slot_pins(state_n, cnt_n);

  always_ff @(posedge CLK or negedge TRST_N) begin
    if (!TRST_N) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      INIT:
        if (fall) begin
          if (cnt == LEN_W'(5)) begin state_n = IDLE; cnt_n = '0; end
          else cnt_n = cnt + LEN_W'(1);
        end
      IDLE:
        if (Start) begin
          if (len_ok) begin accept = 1'b1; state_n = HEAD; cnt_n = '0; end
          else reject = 1'b1;
        end
      HEAD:
        if (fall) begin
          if (cnt == (ir_q ? LEN_W'(3) : LEN_W'(2))) begin state_n = SHIFT; cnt_n = '0; end
          else cnt_n = cnt + LEN_W'(1);
        end
      SHIFT:
        if (fall) begin
          if (cnt == len_q - LEN_W'(1)) begin state_n = TAIL; cnt_n = '0; end
          else cnt_n = cnt + LEN_W'(1);
        end
      TAIL:
        if (fall) begin
          if (cnt == LEN_W'(1)) begin state_n = FIN; cnt_n = '0; end
          else cnt_n = cnt + LEN_W'(1);
        end
      FIN:     state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge TRST_N) begin
    if (!TRST_N) begin
      TCK     <= 1'b0;
      TMS     <= 1'b1;
      TDI     <= 1'b0;
      Busy    <= 1'b1;
      Done    <= 1'b0;
      Err     <= 1'b0;
      DataOut <= '0;
      half    <= '0;
      ir_q    <= 1'b0;
      len_q   <= '0;
      din_q   <= '0;
    end else begin
      Done <= 1'b0;
      Err  <= reject;
      if (half_end) begin
        half <= '0;
        TCK  <= ~TCK;
      end else if (running) begin
        half <= half + HW'(1);
      end else begin
        half <= '0;
      end
      if (rise && state == SHIFT) DataOut[cnt[IW-1:0]] <= TDO;
      if (accept) begin
        ir_q    <= IsIR;
        len_q   <= Len;
        din_q   <= DataIn;
        DataOut <= '0;
        Busy    <= 1'b1;
      end
      // pins only move at slot boundaries, i.e. while TCK is (going) low
      if (accept || fall) {TMS, TDI} <= pins_n;
      if (state == INIT && state_n == IDLE) Busy <= 1'b0;
      if (state == FIN) begin
        Done <= 1'b1;
        Busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural IEEE 1149.1 TAP answers the pins, and
// scan results are predicted from the concatenated shift stream.
module tb_jtag_master;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;

  logic CLK = 1'b0, TRST_N = 1'b0, Start = 1'b0, IsIR = 1'b0;
  logic [LEN_W-1:0]   Len = '0;
  logic [MAX_LEN-1:0] DataIn = '0;
  logic TDO, TCK, TMS, TDI, Busy, Done, Err;
  logic [MAX_LEN-1:0] DataOut;

  always #5 CLK = ~CLK;

  jtag_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .TRST_N(TRST_N), .Start(Start), .IsIR(IsIR), .Len(Len),
    .DataIn(DataIn), .TDO(TDO), .TCK(TCK), .TMS(TMS), .TDI(TDI),
    .Busy(Busy), .Done(Done), .Err(Err), .DataOut(DataOut));

  // ---------------- TAP model ----------------
  typedef enum {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  localparam logic [3:0] IR_CAP = 4'b0001;

  tap_t        tap = TLR;
  logic [63:0] dr = '0, dr_sh = '0, cap_val = '0;
  int          dr_len = 8;
  logic [3:0]  ir = '0, ir_sh = '0;
  int          rises = 0;
  logic        tms_log [0:2047];
  logic        tdi_log [0:2047];

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDS  : RTI;
      SDS:  return m ? SIS  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDS  : RTI;
      SIS:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDS : RTI;
    endcase
  endfunction

  assign TDO = (tap == SHDR) ? dr_sh[0] : (tap == SHIR) ? ir_sh[0] : 1'b0;

  always @(posedge TCK) begin
    if (rises < 2048) begin
      tms_log[rises] = TMS;
      tdi_log[rises] = TDI;
    end
    case (tap)
      CDR:  dr_sh = cap_val;
      SHDR: dr_sh = (dr_sh >> 1) | (64'(TDI) << (dr_len - 1));
      UDR:  dr = dr_sh;
      CIR:  ir_sh = IR_CAP;
      SHIR: ir_sh = {TDI, ir_sh[3:1]};
      UIR:  ir = ir_sh;
      default: ;
    endcase
    tap = tap_next(tap, TMS);
    rises++;
  end

  // ---------------- monitors ----------------
  int errs = 0, hold_viol = 0;
  logic p_tms = 1'b1, p_tdi = 1'b0;
  always @(negedge CLK) begin
    if (Err === 1'b1) errs++;
    if (TRST_N && TCK === 1'b1 && (TMS !== p_tms || TDI !== p_tdi)) hold_viol++;
    p_tms = TMS;
    p_tdi = TDI;
  end

  // ---------------- checking ----------------
  int passed = 0, total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mk(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_pins"}, {58'd0, TCK, TMS, TDI, Busy, Done, Err}, 64'b010100);
    check({tag, "_dout"}, 64'(DataOut), 64'd0);
  endtask

  task automatic release_and_init(input string tag);
    int base, n;
    logic [63:0] tv;
    base = rises;
    n = 0;
    tv = '0;
    TRST_N = 1'b1;
    do begin @(posedge CLK); #1; n++; end while (Busy && n < 500);
    check({tag, "_busy_clks"}, 64'(n), 64'(12 * CLK_DIV));
    check({tag, "_rises"}, 64'(rises - base), 64'd6);
    for (int i = 0; i < 6; i++) tv[i] = tms_log[base + i];
    check({tag, "_tms"}, tv, 64'b011111);
    check({tag, "_tap_rti"}, 64'(tap == RTI), 64'd1);
  endtask

  // One scan; predictions come from stream = {DataIn[Len-1:0], captured register}
  task automatic run_scan(input string tag, input bit is_ir, input int len,
                          input logic [31:0] din, input bit poke,
                          output logic [63:0] upd, output int base);
    int n, busy_n, slots, rlen, head, e0;
    logic [63:0] stream, exp_out, cap, tv;
    rlen    = is_ir ? 4 : dr_len;
    cap     = is_ir ? 64'(IR_CAP) : cap_val;
    stream  = ((64'(din) & mk(len)) << rlen) | cap;
    exp_out = stream & mk(len);
    upd     = (stream >> len) & mk(rlen);
    head    = is_ir ? 4 : 3;
    slots   = len + head + 2;
    base    = rises;
    e0      = errs;
    n = 0;
    busy_n = 0;
    Start = 1'b1; IsIR = is_ir; Len = LEN_W'(len); DataIn = din;
    do begin
      @(posedge CLK); #1;
      n++;
      Start = 1'b0;
      if (poke && n == 20) begin
        Start = 1'b1; Len = LEN_W'(5); DataIn = $urandom; IsIR = ~is_ir;
      end
      if (Busy) busy_n++;
    end while (!Done && n < 5000);
    Start = 1'b0;
    check({tag, "_latency"}, 64'(n - 1), 64'(1 + 2 * CLK_DIV * slots));
    check({tag, "_busy"}, 64'(busy_n), 64'(1 + 2 * CLK_DIV * slots));
    check({tag, "_slots"}, 64'(rises - base), 64'(slots));
    check({tag, "_dout"}, 64'(DataOut), exp_out);
    check({tag, "_reg"}, is_ir ? 64'(ir) : dr, upd);
    check({tag, "_tap_rti"}, 64'(tap == RTI), 64'd1);
    check({tag, "_no_err"}, 64'(errs - e0), 64'd0);
    tv = '0;
    for (int k = 0; k < len; k++) tv[k] = tdi_log[base + head + k];
    check({tag, "_tdi"}, tv, 64'(din) & mk(len));
  endtask

  task automatic bad_start(input string tag, input int len);
    int r0, e0;
    logic [MAX_LEN-1:0] d0;
    r0 = rises; e0 = errs; d0 = DataOut;
    Start = 1'b1; Len = LEN_W'(len);
    @(posedge CLK); #1;
    Start = 1'b0;
    check({tag, "_err"}, 64'(Err), 64'd1);
    repeat (10) begin @(posedge CLK); #1; end
    check({tag, "_err_once"}, 64'(errs - e0), 64'd1);
    check({tag, "_no_tck"}, 64'(rises - r0), 64'd0);
    check({tag, "_idle"}, 64'(Busy), 64'd0);
    check({tag, "_dout_kept"}, 64'(DataOut), 64'(d0));
  endtask

  initial begin
    logic [63:0] upd, tv;
    int base, n, len;
    #12;
    check_reset_vals("reset");
    @(posedge CLK); #1;
    release_and_init("init");

    // DR 8-bit preloaded 0x3C, shift 0xA5
    dr_len = 8; cap_val = 64'h3C;
    run_scan("dr8", 1'b0, 8, 32'hA5, 1'b0, upd, base);

    // IR scan, TMS path checked explicitly
    run_scan("ir4", 1'b1, 4, 32'h2, 1'b0, upd, base);
    tv = '0;
    for (int i = 0; i < 10; i++) tv[i] = tms_log[base + i];
    check("ir4_tms", tv, 64'h183);

    // boundaries, then a back-to-back pair looping the DR
    cap_val = dr;
    run_scan("len1", 1'b0, 1, 32'h1, 1'b0, upd, base);
    dr_len = 32; cap_val = 64'h0BADF00D;
    run_scan("len32a", 1'b0, 32, 32'hDEADBEEF, 1'b0, upd, base);
    cap_val = upd;
    run_scan("len32b", 1'b0, 32, $urandom, 1'b0, upd, base);

    bad_start("len0", 0);
    bad_start("len33", 33);

    // Start during a scan must be ignored
    cap_val = upd;
    run_scan("busy_poke", 1'b0, 16, $urandom, 1'b1, upd, base);
    repeat (5) begin @(posedge CLK); #1; end
    check("busy_poke_idle", 64'(Busy), 64'd0);

    for (int it = 0; it < 6; it++) begin
      case ($urandom_range(0, 2))
        0: dr_len = 8;
        1: dr_len = 16;
        default: dr_len = 32;
      endcase
      cap_val = 64'($urandom) & mk(dr_len);
      len = $urandom_range(1, MAX_LEN);
      run_scan($sformatf("rnd%0d", it), ($urandom_range(0, 3) == 0), len, $urandom, 1'b0, upd, base);
    end

    // abort mid-SHIFT during bit 3 of 8
    dr_len = 8; cap_val = 64'h5A;
    base = rises; n = 0;
    Start = 1'b1; IsIR = 1'b0; Len = LEN_W'(8); DataIn = 32'hC3;
    @(posedge CLK); #1;
    Start = 1'b0;
    while (rises - base < 7 && n < 2000) begin @(negedge CLK); n++; end
    check("abort_reached_shift", 64'(rises - base), 64'd7);
    #2 TRST_N = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (3) @(posedge CLK);
    #1;
    release_and_init("reinit");
    cap_val = 64'h96;
    run_scan("post_abort", 1'b0, 8, $urandom, 1'b0, upd, base);

    check("tck_high_hold", 64'(hold_viol), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/jtag_master.md
# jtag_master

JTAG initiator that drives the TCK/TMS/TDI pins of an IEEE 1149.1 TAP and samples TDO. It is the host-side counterpart of the TAP controller and boundary-scan cells on the device side. A single command performs one complete IR or DR scan of 1..MAX_LEN bits, starting and ending in Run-Test/Idle. It sits between a local command interface (CPU or test sequencer) and the chip-level JTAG pins.

## Interface
- MAX_LEN, 32: maximum scan length in bits.
- LEN_W, 6: width of Len; must hold MAX_LEN.
- CLK_DIV, 2: CLK cycles per TCK half-period; must be ≥1.

- CLK  input  1  system clock; the only clock.
- TRST_N  input  1  asynchronous, active-low reset.
- Start  input  1  one-CLK command strobe; accepted only when Busy=0.
- IsIR  input  1  1 selects an IR scan, 0 selects a DR scan; sampled with Start.
- Len  input  LEN_W  number of bits to shift; sampled with Start.
- DataIn  input  MAX_LEN  bits to shift out, LSB first; sampled with Start.
- TDO  input  1  serial data from the TAP.
- TCK  output  1  generated test clock.
- TMS  output  1  test mode select.
- TDI  output  1  serial data to the TAP.
- Busy  output  1  high during the init sequence or a scan.
- Done  output  1  one-CLK pulse when a scan completes.
- Err  output  1  one-CLK pulse when a command is rejected.
- DataOut  output  MAX_LEN  captured TDO bits; valid from Done until the next accepted Start.

## Operation
- States: INIT, IDLE, HEAD, SHIFT, TAIL, FIN.
- Slot: one TCK period. TCK is low for CLK_DIV CLKs, then high for CLK_DIV CLKs.
  - TMS and TDI update on the CLK edge that drives TCK 1→0, or at slot start.
  - TDO is sampled on the CLK edge that drives TCK 0→1.
- INIT: entered on reset release. Runs 5 slots with TMS=1 (Test-Logic-Reset), then 1 slot with TMS=0 (Run-Test/Idle), then goes to IDLE. Busy=1 throughout. Start is ignored.
- IDLE: TCK=0, TMS=0, TDI=0.
  - Start with 1≤Len≤MAX_LEN: latch IsIR, Len and DataIn; clear DataOut; set Busy; go to HEAD.
  - Start with Len=0 or Len>MAX_LEN: Err pulses on the next CLK; state stays IDLE; DataOut is unchanged.
- HEAD: TMS sequence 1,0,0 for DR (Select-DR, Capture-DR, Shift-DR). For IR the sequence is 1,1,0,0. TDI=0.
- SHIFT: Len slots. Slot k drives TDI=DataIn[k]. TMS=0 except TMS=1 on slot Len-1 (exit to Exit1). The TDO sample in slot k is stored to DataOut[k]. DataOut bits ≥Len stay 0.
- TAIL: TMS sequence 1,0 (Update, Run-Test/Idle). TDI=0.
- FIN: after the final TAIL slot's high phase ends, TCK returns to 0 and Done pulses for one CLK. Busy drops in the same CLK. Next state is IDLE.
- Start while Busy=1 is ignored, with no Err.
- Asynchronous TRST_N assertion at any time, including mid-scan, aborts immediately. After release the block re-enters INIT; the TAP is resynchronised by the 5×TMS=1 slots.

## Timing
- Reset values: TCK=0, TMS=1, TDI=0, Busy=1, Done=0, Err=0, DataOut=0. State is INIT.
- INIT duration: 6 slots = 12·CLK_DIV CLKs. Busy falls on the first CLK after that.
- First slot begins on the CLK after Start is accepted.
- DR scan: Len+5 slots. IR scan: Len+6 slots.
- Start-to-Done latency: 1 + 2·CLK_DIV·(slots) CLKs. Busy spans exactly that window.
- Done and Busy→0 occur in the same CLK. A new Start is accepted in the very next CLK (back-to-back scans).
- DataOut is stable from Done until the next accepted Start.
- TMS and TDI never change while TCK=1.

## Test plan
- Reset/init: release TRST_N with CLK_DIV=2 -> exactly 5 TCK rises with TMS=1, then 1 with TMS=0. Busy falls 24 CLKs after release.
- DR scan, TAP model with an 8-bit DR preloaded with 0x3C: Len=8, DataIn=0xA5 -> 13 TCK periods; TDI sequence 1,0,1,0,0,1,0,1; DataOut=0x3C; model DR updates to 0xA5; Done pulse at CLK 1+4·13=53.
- IR scan: Len=4, DataIn=0x2, model IR capture value 0b0001 -> 10 slots; TMS sequence 1,1,0,0,0,0,0,1,1,0; DataOut=0x1; model IR=0x2.
- Boundaries: Len=1 and Len=32 (DataIn=0xDEADBEEF with TDO looped from the model DR) -> correct slot counts. Len=0 and Len=33 -> Err pulse, no TCK activity.
- Start while Busy: a second Start mid-scan -> ignored; no Err; first scan results intact. Back-to-back Start in the CLK after Done -> accepted.
- Reset mid-SHIFT: assert TRST_N during bit 3 of 8 -> outputs go to reset values immediately. After release the INIT sequence repeats and a following DR scan completes correctly.
